// File: rtl/stepper_phase_decoder_pkg.sv
// Shared definitions for the stepper phase decoder:
// half-step phase table, tracker states and code lookup.
package stepper_phase_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        FAULT
    } state_t;

    // Index 0 sits in the low nibble.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

    localparam logic [3:0] IDX_ILLEGAL = 4'd8;

    function automatic logic [3:0] phase_index(input logic [3:0] code);
        logic [3:0] idx;
        idx = IDX_ILLEGAL;
        for (int i = 0; i < 8; i++) begin
            if (PHASE_TABLE[i] == code) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/stepper_phase_decoder_phase_filter.sv
// Input register plus stability counter; the registered
// code is reported as accepted once it has been steady.
module stepper_phase_decoder_phase_filter
    import stepper_phase_decoder_pkg::*;
#(
    parameter int FILTER_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] stepper_signals,
    output logic [3:0] code,
    output logic       valid
);

    localparam logic [3:0] FC = 4'(FILTER_CYCLES);

    logic [3:0] count;

    // Register the input and count how long it has been stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code  <= 4'b0000;
            count <= 4'd0;
        end else if (stepper_signals != code) begin
            code  <= stepper_signals;
            count <= 4'd1;
        end else if (count < FC) begin
            count <= count + 4'd1;
        end
    end

    assign valid = (count >= FC);

endmodule

// File: rtl/stepper_phase_decoder.sv
// Closed-loop monitor: decodes the stepper phase pattern into
// position, direction, step events and step interval.
module stepper_phase_decoder
    import stepper_phase_decoder_pkg::*;
#(
    parameter int FILTER_CYCLES  = 2,
    parameter int POS_WIDTH      = 8,
    parameter int INTERVAL_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                stepper_signals,
    input  logic                      zero_position,
    input  logic                      clear_fault,
    output logic [POS_WIDTH-1:0]      position,
    output logic                      direction,
    output logic                      step_pulse,
    output logic                      locked,
    output logic                      fault,
    output logic [INTERVAL_WIDTH-1:0] last_interval
);

    state_t                    state, state_n;
    logic [2:0]                ref_idx, ref_idx_n;
    logic [POS_WIDTH-1:0]      position_n;
    logic                      direction_n;
    logic                      step_pulse_n;
    logic                      locked_n;
    logic                      fault_n;
    logic [INTERVAL_WIDTH-1:0] last_interval_n;
    logic [INTERVAL_WIDTH-1:0] timer, timer_n;

    logic [3:0] code;
    logic       valid;
    logic [3:0] idx;
    logic       legal;
    logic [2:0] delta;

    stepper_phase_decoder_phase_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .clk            (clk),
        .reset          (reset),
        .stepper_signals(stepper_signals),
        .code           (code),
        .valid          (valid)
    );

    assign idx   = phase_index(code);
    assign legal = (idx != IDX_ILLEGAL);
    assign delta = idx[2:0] - ref_idx;

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ref_idx       <= 3'd0;
            position      <= '0;
            direction     <= 1'b1;
            step_pulse    <= 1'b0;
            locked        <= 1'b0;
            fault         <= 1'b0;
            last_interval <= '0;
            timer         <= '0;
        end else begin
            state         <= state_n;
            ref_idx       <= ref_idx_n;
            position      <= position_n;
            direction     <= direction_n;
            step_pulse    <= step_pulse_n;
            locked        <= locked_n;
            fault         <= fault_n;
            last_interval <= last_interval_n;
            timer         <= timer_n;
        end
    end

    // Tracker: evaluate accepted codes against the reference phase.
    always_comb begin
        state_n         = state;
        ref_idx_n       = ref_idx;
        position_n      = position;
        direction_n     = direction;
        step_pulse_n    = 1'b0;
        locked_n        = locked;
        fault_n         = fault;
        last_interval_n = last_interval;

        if (state == TRACK) begin
            timer_n = (&timer) ? timer : timer + 1'b1;
        end else begin
            timer_n = '0;
        end

        if (clear_fault) begin
            state_n  = IDLE;
            fault_n  = 1'b0;
            locked_n = 1'b0;
        end else if (valid) begin
            unique case (state)
                IDLE: begin
                    if (legal) begin
                        ref_idx_n = idx[2:0];
                        locked_n  = 1'b1;
                        state_n   = TRACK;
                    end
                end
                TRACK: begin
                    if (!legal || delta == 3'd3 ||
                        delta == 3'd4 || delta == 3'd5) begin
                        fault_n  = 1'b1;
                        locked_n = 1'b0;
                        state_n  = FAULT;
                    end else if (delta != 3'd0) begin
                        // 6/7 read as -2/-1 when sign-extended.
                        position_n = position +
                            {{(POS_WIDTH-3){delta[2]}}, delta};
                        direction_n     = ~delta[2];
                        step_pulse_n    = 1'b1;
                        ref_idx_n       = idx[2:0];
                        last_interval_n = timer;
                        timer_n         = INTERVAL_WIDTH'(1);
                    end
                end
                FAULT: begin
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        if (zero_position) begin
            position_n = '0;
        end
    end

endmodule
